// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: per-stage write enables, flushes and next-PC select for the
// 5-stage core, plus halt tracking and a saturating stall-cycle counter.
module pipeline_hazard_ctrl #(
    parameter int STALL_CNT_W = 16,
    parameter int REG_W       = 5
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic                   ihit,
    input  logic                   dhit,
    input  logic                   mem_ren,
    input  logic                   mem_wen,
    input  logic                   mem_br_taken,
    input  logic                   mem_halt,
    input  logic                   ex_memread,
    input  logic [REG_W-1:0]       ex_rd,
    input  logic [REG_W-1:0]       id_rs,
    input  logic [REG_W-1:0]       id_rt,
    input  logic                   id_jump,
    output logic                   pc_wen,
    output logic [1:0]             pc_sel,
    output logic                   ifid_wen,
    output logic                   idex_wen,
    output logic                   exmem_wen,
    output logic                   memwb_wen,
    output logic                   ifid_flush,
    output logic                   idex_flush,
    output logic                   exmem_flush,
    output logic                   halted,
    output logic [STALL_CNT_W-1:0] stall_count
);

    localparam logic [1:0] RUN    = 2'd0;
    localparam logic [1:0] DWAIT  = 2'd1;
    localparam logic [1:0] HALTED = 2'd2;

    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       data_wait;
    logic       load_use;

    assign data_wait = (mem_ren | mem_wen) & ~dhit;
    assign load_use  = ex_memread && (ex_rd != '0) && ((ex_rd == id_rs) || (ex_rd == id_rt));

    always_comb begin
        pc_wen      = 1'b1;
        pc_sel      = PC_SEQ;
        ifid_wen    = 1'b1;
        idex_wen    = 1'b1;
        exmem_wen   = 1'b1;
        memwb_wen   = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        state_nxt   = state;

        if (!nRST || state == HALTED || data_wait) begin
            pc_wen    = 1'b0;
            ifid_wen  = 1'b0;
            idex_wen  = 1'b0;
            exmem_wen = 1'b0;
            memwb_wen = 1'b0;
            if (nRST && state != HALTED) begin
                state_nxt = DWAIT;
            end
        end else if (mem_halt) begin
            // Only MEM/WB moves so the HALT itself retires; everything behind it freezes.
            pc_wen    = 1'b0;
            ifid_wen  = 1'b0;
            idex_wen  = 1'b0;
            exmem_wen = 1'b0;
            state_nxt = HALTED;
        end else begin
            state_nxt = RUN;
            if (mem_br_taken) begin
                pc_sel      = PC_BRANCH;
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
            end else if (load_use) begin
                // A jump in ID waits behind the load-use bubble and is re-evaluated next cycle.
                pc_wen     = 1'b0;
                ifid_wen   = 1'b0;
                idex_flush = 1'b1;
            end else if (id_jump) begin
                pc_wen     = ihit;
                pc_sel     = PC_JUMP;
                ifid_flush = 1'b1;
            end else if (!ihit) begin
                pc_wen     = 1'b0;
                ifid_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state       <= RUN;
            halted      <= 1'b0;
            stall_count <= '0;
        end else begin
            state  <= state_nxt;
            halted <= (state_nxt == HALTED);
            if (!pc_wen && state != HALTED && stall_count != '1) begin
                stall_count <= stall_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized and directed bench for pipeline_hazard_ctrl against a rule-level model;
// a second instance with a 4-bit counter exercises saturation.
module tb_pipeline_hazard_ctrl;

    logic       CLK = 1'b0;
    logic       nRST = 1'b0;
    logic       ihit = 1'b0, dhit = 1'b0, mem_ren = 1'b0, mem_wen = 1'b0;
    logic       mem_br_taken = 1'b0, mem_halt = 1'b0, ex_memread = 1'b0, id_jump = 1'b0;
    logic [4:0] ex_rd = '0, id_rs = '0, id_rt = '0;

    logic        pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen;
    logic        ifid_flush, idex_flush, exmem_flush, halted;
    logic [1:0]  pc_sel;
    logic [15:0] stall_count;

    logic       q_pc_wen, q_ifid_wen, q_idex_wen, q_exmem_wen, q_memwb_wen;
    logic       q_ifid_flush, q_idex_flush, q_exmem_flush, q_halted;
    logic [1:0] q_pc_sel;
    logic [3:0] q_stall_count;

    int checks = 0;
    int failures = 0;

    bit m_halted = 1'b0;
    int m_cnt = 0;
    int m_cnt4 = 0;

    always #5 CLK = ~CLK;

    pipeline_hazard_ctrl #(.STALL_CNT_W(16), .REG_W(5)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_ren(mem_ren), .mem_wen(mem_wen),
        .mem_br_taken(mem_br_taken), .mem_halt(mem_halt), .ex_memread(ex_memread),
        .ex_rd(ex_rd), .id_rs(id_rs), .id_rt(id_rt), .id_jump(id_jump),
        .pc_wen(pc_wen), .pc_sel(pc_sel), .ifid_wen(ifid_wen), .idex_wen(idex_wen),
        .exmem_wen(exmem_wen), .memwb_wen(memwb_wen), .ifid_flush(ifid_flush),
        .idex_flush(idex_flush), .exmem_flush(exmem_flush), .halted(halted),
        .stall_count(stall_count)
    );

    pipeline_hazard_ctrl #(.STALL_CNT_W(4), .REG_W(5)) dut4 (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_ren(mem_ren), .mem_wen(mem_wen),
        .mem_br_taken(mem_br_taken), .mem_halt(mem_halt), .ex_memread(ex_memread),
        .ex_rd(ex_rd), .id_rs(id_rs), .id_rt(id_rt), .id_jump(id_jump),
        .pc_wen(q_pc_wen), .pc_sel(q_pc_sel), .ifid_wen(q_ifid_wen), .idex_wen(q_idex_wen),
        .exmem_wen(q_exmem_wen), .memwb_wen(q_memwb_wen), .ifid_flush(q_ifid_flush),
        .idex_flush(q_idex_flush), .exmem_flush(q_exmem_flush), .halted(q_halted),
        .stall_count(q_stall_count)
    );

    wire [9:0] dut_vec = {pc_wen, pc_sel, ifid_wen, idex_wen, exmem_wen, memwb_wen,
                          ifid_flush, idex_flush, exmem_flush};

    // Rule-level model of the combinational strobes for the current inputs.
    function automatic logic [9:0] exp_out(input bit h);
        logic pw, fw, dw, ew, mw, ff, df, ef;
        logic [1:0] ps;
        bit hazard;
        pw = 1; ps = 2'b00; fw = 1; dw = 1; ew = 1; mw = 1; ff = 0; df = 0; ef = 0;
        hazard = ex_memread && ex_rd != 0 && (ex_rd == id_rs || ex_rd == id_rt);
        if (h || ((mem_ren || mem_wen) && !dhit)) begin
            pw = 0; fw = 0; dw = 0; ew = 0; mw = 0;
        end else if (mem_halt) begin
            pw = 0; fw = 0; dw = 0; ew = 0;
        end else if (mem_br_taken) begin
            ps = 2'b01; ff = 1; df = 1; ef = 1;
        end else if (hazard) begin
            pw = 0; fw = 0; df = 1;
        end else if (id_jump) begin
            pw = ihit; ps = 2'b10; ff = 1;
        end else if (!ihit) begin
            pw = 0; ff = 1;
        end
        return {pw, ps, fw, dw, ew, mw, ff, df, ef};
    endfunction

    // Advance the model by one clock edge using the inputs held during that cycle.
    task automatic model_tick();
        logic [9:0] e;
        e = exp_out(m_halted);
        if (!m_halted) begin
            if (!e[9]) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt4 < 15) m_cnt4++;
            end
            if (!((mem_ren || mem_wen) && !dhit) && mem_halt) m_halted = 1'b1;
        end
    endtask

    task automatic clear_inputs();
        ihit = 1; dhit = 0; mem_ren = 0; mem_wen = 0; mem_br_taken = 0; mem_halt = 0;
        ex_memread = 0; id_jump = 0; ex_rd = 0; id_rs = 0; id_rt = 0;
    endtask

    task automatic do_reset();
        nRST = 0;
        clear_inputs();
        repeat (2) @(posedge CLK);
        #1 nRST = 1;
        m_halted = 0; m_cnt = 0; m_cnt4 = 0;
    endtask

    // Check one cycle against the model at the negative edge, then step the edge.
    task automatic cycle();
        @(negedge CLK);
        checks++;
        if (dut_vec !== exp_out(m_halted)) begin
            failures++;
            $display("FAIL strobes t=%0t got=%b want=%b", $time, dut_vec, exp_out(m_halted));
        end
        @(posedge CLK);
        model_tick();
        #1;
    endtask

    task automatic test_reset();
        nRST = 0;
        clear_inputs();
        #3;
        checks++;
        if ({dut_vec, halted, stall_count} !== 27'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%b/%b/%0d want=0", dut_vec, halted, stall_count);
        end
        do_reset();
    endtask

    task automatic test_idle();
        repeat (3) cycle();
        checks++;
        if (dut_vec !== 10'b1_00_1111_000 || stall_count !== 16'd0) begin
            failures++;
            $display("FAIL idle got=%b cnt=%0d want=1001111000 cnt=0", dut_vec, stall_count);
        end
    endtask

    task automatic test_dwait();
        do_reset();
        mem_ren = 1; dhit = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            checks++;
            if ({pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen} !== 5'b0) begin
                failures++;
                $display("FAIL dwait_freeze cyc=%0d got=%b want=00000", i,
                         {pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen});
            end
            @(posedge CLK); model_tick(); #1;
        end
        checks++;
        if (stall_count !== 16'd3) begin
            failures++;
            $display("FAIL dwait_count got=%0d want=3", stall_count);
        end
        dhit = 1;
        @(negedge CLK);
        checks++;
        if ({pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen} !== 5'b11111) begin
            failures++;
            $display("FAIL dwait_release got=%b want=11111",
                     {pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen});
        end
        @(posedge CLK); model_tick(); #1;
        clear_inputs();
        cycle();
        checks++;
        if (stall_count !== 16'd3) begin
            failures++;
            $display("FAIL dwait_count_hold got=%0d want=3", stall_count);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        ex_memread = 1; ex_rd = 5; id_rt = 5; id_rs = 2;
        @(negedge CLK);
        checks++;
        if ({pc_wen, ifid_wen, idex_flush, exmem_wen, memwb_wen} !== 5'b00111) begin
            failures++;
            $display("FAIL load_use got=%b want=00111",
                     {pc_wen, ifid_wen, idex_flush, exmem_wen, memwb_wen});
        end
        @(posedge CLK); model_tick(); #1;
        ex_rd = 0; id_rt = 0; id_rs = 0;
        @(negedge CLK);
        checks++;
        if ({pc_wen, ifid_wen, idex_flush} !== 3'b110) begin
            failures++;
            $display("FAIL load_use_r0 got=%b want=110", {pc_wen, ifid_wen, idex_flush});
        end
        @(posedge CLK); model_tick(); #1;
        ex_rd = 7; id_rs = 7; id_jump = 1;
        cycle();
        clear_inputs();
    endtask

    task automatic test_branch();
        do_reset();
        mem_br_taken = 1; ex_memread = 1; ex_rd = 3; id_rs = 3; ihit = 0;
        @(negedge CLK);
        checks++;
        if ({pc_sel, pc_wen, ifid_flush, idex_flush, exmem_flush} !== 6'b01_1111) begin
            failures++;
            $display("FAIL branch got=%b want=011111",
                     {pc_sel, pc_wen, ifid_flush, idex_flush, exmem_flush});
        end
        @(posedge CLK); model_tick(); #1;
        mem_wen = 1; dhit = 0;
        @(negedge CLK);
        checks++;
        if (dut_vec !== 10'b0_00_0000_000) begin
            failures++;
            $display("FAIL branch_dwait got=%b want=0000000000", dut_vec);
        end
        @(posedge CLK); model_tick(); #1;
        clear_inputs();
    endtask

    task automatic test_halt();
        do_reset();
        mem_halt = 1; mem_br_taken = 1;
        @(negedge CLK);
        checks++;
        if ({pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen, exmem_flush} !== 6'b000010) begin
            failures++;
            $display("FAIL halt_retire got=%b want=000010",
                     {pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen, exmem_flush});
        end
        @(posedge CLK); model_tick(); #1;
        for (int i = 0; i < 10; i++) begin
            ihit = 1'($urandom); mem_br_taken = 1'($urandom); id_jump = 1'($urandom);
            mem_halt = 1'($urandom);
            @(negedge CLK);
            checks++;
            if (halted !== 1'b1 || {pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen} !== 5'b0) begin
                failures++;
                $display("FAIL halted_hold cyc=%0d halted=%b wen=%b want 1/00000", i, halted,
                         {pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen});
            end
            @(posedge CLK); model_tick(); #1;
        end
        #2 nRST = 0;
        #1;
        checks++;
        if (halted !== 1'b0 || stall_count !== 16'd0) begin
            failures++;
            $display("FAIL halt_reset halted=%b cnt=%0d want 0/0", halted, stall_count);
        end
        do_reset();
    endtask

    task automatic test_saturate();
        do_reset();
        ihit = 0;
        repeat (20) cycle();
        checks++;
        if (q_stall_count !== 4'd15 || stall_count !== 16'd20) begin
            failures++;
            $display("FAIL saturate cnt4=%0d cnt16=%0d want 15/20", q_stall_count, stall_count);
        end
        clear_inputs();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            ihit = ($urandom_range(0, 3) != 0);
            mem_ren = ($urandom_range(0, 3) == 0);
            mem_wen = ($urandom_range(0, 5) == 0);
            dhit = 1'($urandom);
            mem_br_taken = ($urandom_range(0, 4) == 0);
            mem_halt = ($urandom_range(0, 30) == 0);
            ex_memread = 1'($urandom);
            id_jump = ($urandom_range(0, 4) == 0);
            ex_rd = 5'($urandom_range(0, 3));
            id_rs = 5'($urandom_range(0, 3));
            id_rt = 5'($urandom_range(0, 3));
            cycle();
            checks++;
            if (halted !== m_halted || stall_count !== 16'(m_cnt) || q_stall_count !== 4'(m_cnt4)) begin
                failures++;
                $display("FAIL rand_state i=%0d halted=%b cnt=%0d cnt4=%0d want %b/%0d/%0d", i,
                         halted, stall_count, q_stall_count, m_halted, m_cnt, m_cnt4);
            end
            if (m_halted && $urandom_range(0, 3) == 0) do_reset();
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_idle();
        test_dwait();
        test_load_use();
        test_branch();
        test_halt();
        test_saturate();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
